bfifo_w3_pack: RTL and testbench

BFIFO_W3_PACK -- requirements
Module: bfifo_w3_pack

---
 rtl/bfifo_w3_pack.sv | 78 +++++++
 tb/tb_bfifo_w3_pack.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bfifo_w3_pack.sv
// rtl/bfifo_w3_pack.sv - packs 3-bit FIFO codes into 18-bit words of up to five codes
module bfifo_w3_pack #(
  parameter int FLUSH_TO = 255
) (
  input  logic        RCLOCK,
  input  logic        RESET,
  input  logic        EN,
  input  logic        EMPTY,
  input  logic [2:0]  RDATA,
  output logic        RE,
  output logic [17:0] O_DATA,
  output logic        O_VALID,
  input  logic        I_READY
);

  localparam logic [7:0] IDLE_MAX = 8'(FLUSH_TO);

  logic [2:0]  pack_cnt;
  logic        rd_pend;
  logic [14:0] pack_reg;
  logic [7:0]  idle;

  logic        full;
  logic        flush;
  logic        emit;
  logic [14:0] pack_nxt;
  logic [2:0]  cnt_nxt;

  assign full  = (pack_cnt == 3'd5);
  assign flush = (idle == IDLE_MAX) && (pack_cnt != 3'd0) && !full && !rd_pend;
  assign emit  = (full || flush) && (!O_VALID || I_READY);

  // A code in flight already owns a slot, so it counts against the five.
  assign RE = RESET && EN && !EMPTY &&
              (({1'b0, pack_cnt} + {3'b000, rd_pend}) < 4'd5);

  always_comb begin
    pack_nxt = emit ? 15'd0 : pack_reg;
    cnt_nxt  = emit ? 3'd0  : pack_cnt;
    if (rd_pend && (cnt_nxt != 3'd5)) begin
      for (int i = 0; i < 5; i++) begin
        if (cnt_nxt == 3'(i)) begin
          pack_nxt[i*3 +: 3] = RDATA;
        end
      end
      cnt_nxt = cnt_nxt + 3'd1;
    end
  end

  always_ff @(posedge RCLOCK or negedge RESET) begin
    if (!RESET) begin
      pack_cnt <= 3'd0;
      rd_pend  <= 1'b0;
      pack_reg <= 15'd0;
      idle     <= 8'd0;
      O_DATA   <= 18'd0;
      O_VALID  <= 1'b0;
    end else begin
      rd_pend  <= RE;
      pack_reg <= pack_nxt;
      pack_cnt <= cnt_nxt;

      if (emit) begin
        O_DATA  <= {pack_cnt, pack_reg};
        O_VALID <= 1'b1;
      end else if (I_READY) begin
        O_VALID <= 1'b0;
      end

      if (emit || rd_pend || (pack_cnt == 3'd0)) begin
        idle <= 8'd0;
      end else if (idle != IDLE_MAX) begin
        idle <= idle + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_bfifo_w3_pack.sv
// tb/tb_bfifo_w3_pack.sv - directed bench for bfifo_w3_pack with a behavioural read-side FIFO
module tb_bfifo_w3_pack;

  logic        RCLOCK = 1'b0;
  logic        RESET;
  logic        EN;
  logic        EMPTY;
  logic [2:0]  RDATA;
  logic        RE;
  logic [17:0] O_DATA;
  logic        O_VALID;
  logic        I_READY;

  bfifo_w3_pack #(.FLUSH_TO(4)) dut (
    .RCLOCK (RCLOCK),
    .RESET  (RESET),
    .EN     (EN),
    .EMPTY  (EMPTY),
    .RDATA  (RDATA),
    .RE     (RE),
    .O_DATA (O_DATA),
    .O_VALID(O_VALID),
    .I_READY(I_READY)
  );

  always #5 RCLOCK = ~RCLOCK;

  int tests_run = 0;
  int tests_failed = 0;

  logic [2:0]  q[$];
  logic [2:0]  pops[$];
  logic [17:0] words[$];
  int          word_cyc[$];
  logic        pend_valid;
  logic [2:0]  pend_code;
  logic        en_v, rdy_v;
  logic        re_s, ov_s;
  logic [17:0] od_s;
  int          re_cnt = 0;
  int          cyc = 0;

  // One clock: inputs change on the falling edge, outputs are sampled 1 ns later.
  task automatic cycle();
    @(negedge RCLOCK);
    EN      = en_v;
    I_READY = rdy_v;
    RDATA   = pend_valid ? pend_code : 3'd0;
    EMPTY   = (q.size() == 0);
    #1;
    re_s = RE;
    ov_s = O_VALID;
    od_s = O_DATA;
    pend_valid = 1'b0;
    if (re_s) begin
      pend_code  = (q.size() > 0) ? q.pop_front() : 3'd0;
      pend_valid = 1'b1;
      pops.push_back(pend_code);
      re_cnt++;
    end
    if (ov_s && I_READY) begin
      words.push_back(od_s);
      word_cyc.push_back(cyc);
    end
    cyc++;
  endtask

  task automatic reset_dut();
    RESET = 1'b0;
    q.delete(); pops.delete(); words.delete(); word_cyc.delete();
    pend_valid = 1'b0; en_v = 1'b0; rdy_v = 1'b0;
    repeat (2) cycle();
    RESET = 1'b1;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    q = '{3'd1, 3'd2, 3'd3};
    en_v = 1'b1; rdy_v = 1'b1;
    repeat (2) cycle();
    tests_run++;
    if (re_s !== 1'b0) begin tests_failed++; $display("FAIL reset_re got=%b exp=0", re_s); end
    tests_run++;
    if (ov_s !== 1'b0) begin tests_failed++; $display("FAIL reset_ovalid got=%b exp=0", ov_s); end
    tests_run++;
    if (od_s !== 18'h0) begin tests_failed++; $display("FAIL reset_odata got=%h exp=0", od_s); end
    RESET = 1'b1;
    cycle();
    tests_run++;
    if (re_s !== 1'b1) begin tests_failed++; $display("FAIL first_re_after_release got=%b exp=1", re_s); end
  endtask

  task automatic test_full_word();
    logic [17:0] exp_w, got;
    int re0, ovc;
    exp_w = {3'd5, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
    reset_dut();
    q = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    en_v = 1'b1; rdy_v = 1'b1;
    re0 = re_cnt; ovc = 0;
    repeat (30) begin
      cycle();
      if (ov_s) ovc++;
    end
    got = (words.size() > 0) ? words[0] : 18'h3FFFF;
    tests_run++;
    if (got !== exp_w) begin tests_failed++; $display("FAIL full_word_data got=%h exp=%h", got, exp_w); end
    tests_run++;
    if (words.size() != 1) begin tests_failed++; $display("FAIL full_word_count got=%0d exp=1", words.size()); end
    tests_run++;
    if (re_cnt - re0 != 5) begin tests_failed++; $display("FAIL full_word_re_pulses got=%0d exp=5", re_cnt - re0); end
    tests_run++;
    if (ovc != 1) begin tests_failed++; $display("FAIL full_word_valid_cycles got=%0d exp=1", ovc); end
  endtask

  task automatic test_flush();
    logic [17:0] exp_w, got;
    int last_re, first_ov;
    exp_w = {3'd2, 9'd0, 3'd6, 3'd7};
    reset_dut();
    q = '{3'd7, 3'd6};
    en_v = 1'b1; rdy_v = 1'b1;
    last_re = -100; first_ov = -1;
    repeat (20) begin
      cycle();
      if (re_s) last_re = cyc;
      if (ov_s && first_ov < 0) first_ov = cyc;
    end
    got = (words.size() > 0) ? words[0] : 18'h3FFFF;
    tests_run++;
    if (got !== exp_w) begin tests_failed++; $display("FAIL flush_word got=%h exp=%h", got, exp_w); end
    tests_run++;
    if (first_ov - last_re != 7) begin tests_failed++; $display("FAIL flush_latency got=%0d exp=7", first_ov - last_re); end
  endtask

  task automatic test_backpressure();
    logic [17:0] w1, w2, w3;
    int re0, seen, bad, re_late;
    w1 = {3'd5, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
    w2 = {3'd5, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6};
    w3 = {3'd5, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3};
    reset_dut();
    q = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2,
          3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    en_v = 1'b1; rdy_v = 1'b0;
    re0 = re_cnt; seen = 0; bad = 0; re_late = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (ov_s) begin
        seen++;
        if (od_s !== w1) bad++;
      end
      if (i >= 20 && re_s) re_late++;
    end
    tests_run++;
    if (bad != 0 || seen != 33) begin tests_failed++; $display("FAIL bp_hold_stable bad=%0d seen=%0d exp bad=0 seen=33", bad, seen); end
    tests_run++;
    if (re_cnt - re0 != 10 || re_late != 0) begin tests_failed++; $display("FAIL bp_re_stop got=%0d late=%0d exp=10 late=0", re_cnt - re0, re_late); end
    tests_run++;
    if (dut.pack_cnt !== 3'd5) begin tests_failed++; $display("FAIL bp_pack_full got=%0d exp=5", dut.pack_cnt); end
    rdy_v = 1'b1;
    cycle();
    cycle();
    tests_run++;
    if (ov_s !== 1'b1 || od_s !== w2) begin tests_failed++; $display("FAIL bp_zero_bubble got=%b/%h exp=1/%h", ov_s, od_s, w2); end
    repeat (30) cycle();
    tests_run++;
    if (words.size() != 3) begin tests_failed++; $display("FAIL bp_word_count got=%0d exp=3", words.size()); end
    else begin
      tests_run++;
      if (words[0] !== w1 || words[1] !== w2 || words[2] !== w3) begin
        tests_failed++;
        $display("FAIL bp_word_order got=%h %h %h exp=%h %h %h", words[0], words[1], words[2], w1, w2, w3);
      end
    end
  endtask

  task automatic test_stream();
    int re0, viol, bad, idx, gap_bad;
    logic [17:0] w;
    int cnt;
    reset_dut();
    for (int i = 0; i < 70; i++) q.push_back(3'((i * 5 + 3) & 7));
    en_v = 1'b1; rdy_v = 1'b1;
    re0 = re_cnt; viol = 0;
    repeat (70) begin
      cycle();
      if (re_s && (dut.pack_cnt + dut.rd_pend == 5)) viol++;
    end
    en_v = 1'b0;
    repeat (30) cycle();
    tests_run++;
    if (re_cnt - re0 < 50) begin tests_failed++; $display("FAIL stream_codes got=%0d exp>=50", re_cnt - re0); end
    tests_run++;
    if (viol != 0) begin tests_failed++; $display("FAIL stream_re_when_full got=%0d exp=0", viol); end
    bad = 0; idx = 0;
    foreach (words[k]) begin
      w = words[k];
      cnt = int'(w[17:15]);
      for (int j = 0; j < 5; j++) begin
        if (j < cnt) begin
          if (idx >= pops.size() || w[j*3 +: 3] !== pops[idx]) bad++;
          idx++;
        end else if (w[j*3 +: 3] !== 3'd0) begin
          bad++;
        end
      end
    end
    tests_run++;
    if (bad != 0 || idx != pops.size()) begin tests_failed++; $display("FAIL stream_order bad=%0d packed=%0d popped=%0d", bad, idx, pops.size()); end
    gap_bad = 0;
    for (int k = 1; k < words.size(); k++) begin
      if (words[k][17:15] == 3'd5 && words[k-1][17:15] == 3'd5 && word_cyc[k] - word_cyc[k-1] > 7) gap_bad++;
    end
    tests_run++;
    if (gap_bad != 0 || words.size() < 10) begin tests_failed++; $display("FAIL stream_back_to_back gaps=%0d words=%0d exp 0/>=10", gap_bad, words.size()); end
  endtask

  task automatic test_reset_mid();
    logic found;
    logic [17:0] exp_w, got;
    exp_w = {3'd2, 9'd0, 3'd5, 3'd2};
    reset_dut();
    repeat (10) q.push_back(3'd7);
    en_v = 1'b1; rdy_v = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      if (dut.pack_cnt == 3'd3 && dut.rd_pend && ov_s) found = 1'b1;
    end
    tests_run++;
    if (found !== 1'b1) begin tests_failed++; $display("FAIL rmid_reach_state got=%b exp=1", found); end
    RESET = 1'b0;
    #1;
    tests_run++;
    if (RE !== 1'b0 || O_VALID !== 1'b0 || O_DATA !== 18'h0) begin
      tests_failed++;
      $display("FAIL rmid_immediate_clear got=%b/%b/%h exp=0/0/0", RE, O_VALID, O_DATA);
    end
    q.delete(); words.delete(); pend_valid = 1'b0;
    repeat (2) cycle();
    q = '{3'd2, 3'd5};
    rdy_v = 1'b1;
    RESET = 1'b1;
    repeat (20) cycle();
    got = (words.size() > 0) ? words[0] : 18'h3FFFF;
    tests_run++;
    if (got !== exp_w || words.size() != 1) begin tests_failed++; $display("FAIL rmid_post_reset_word got=%h n=%0d exp=%h n=1", got, words.size(), exp_w); end
  endtask

  task automatic test_en_drop();
    logic [17:0] exp_w, got;
    int re0, last_re, first_ov, extra;
    exp_w = {3'd2, 9'd0, 3'd6, 3'd4};
    reset_dut();
    q = '{3'd4, 3'd6, 3'd1, 3'd1, 3'd1, 3'd1};
    en_v = 1'b1; rdy_v = 1'b1;
    re0 = re_cnt;
    cycle();
    cycle();
    last_re = cyc;
    en_v = 1'b0;
    first_ov = -1; extra = 0;
    repeat (25) begin
      cycle();
      if (re_s) extra++;
      if (ov_s && first_ov < 0) first_ov = cyc;
    end
    got = (words.size() > 0) ? words[0] : 18'h3FFFF;
    tests_run++;
    if (re_cnt - re0 != 2 || extra != 0) begin tests_failed++; $display("FAIL endrop_re got=%0d extra=%0d exp=2 extra=0", re_cnt - re0, extra); end
    tests_run++;
    if (got !== exp_w || words.size() != 1) begin tests_failed++; $display("FAIL endrop_word got=%h n=%0d exp=%h n=1", got, words.size(), exp_w); end
    tests_run++;
    if (first_ov - last_re != 7) begin tests_failed++; $display("FAIL endrop_flush_latency got=%0d exp=7", first_ov - last_re); end
  endtask

  initial begin
    RESET = 1'b0; EN = 1'b0; EMPTY = 1'b1; RDATA = 3'd0; I_READY = 1'b0;
    pend_valid = 1'b0; pend_code = 3'd0; en_v = 1'b0; rdy_v = 1'b0;
    re_s = 1'b0; ov_s = 1'b0; od_s = 18'h0;
    test_reset();
    test_full_word();
    test_flush();
    test_backpressure();
    test_stream();
    test_reset_mid();
    test_en_drop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
